pwm_duty_decoder: RTL

Measures an incoming PWM waveform and reports its period, its high time and its duty cycle in tenths (0..10). It is the receive-side counterpart of the button-controlled 10-step PWM generator, for loop-back checking and for reading external PWM sources. The input is asynchronous and is synchronized internally. Measurements are made between consecutive rising edges, and the duty is computed by a fixed-latency sequential divider.

---
 rtl/pwm_duty_decoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures an asynchronous PWM input between consecutive
// rising edges and reports period, high time and duty in tenths (0..10).
// Ports:
//   clk, rst_n   clock (rising edge) and async active-low reset
//   ena          capture enable; low forces idle and holds the outputs
//   pwm_in       asynchronous PWM input
//   period_cnt   last measured period in clk cycles
//   high_cnt     last measured high time in clk cycles
//   duty         floor(10*high_cnt/period_cnt)
//   valid        one-cycle pulse when the outputs update
//   stuck        no rising edge seen for TIMEOUT cycles
module pwm_duty_decoder #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [3:0]       duty,
    output logic             valid,
    output logic             stuck
);

    localparam int unsigned REM_W = CNT_W + 4;
    localparam logic [CNT_W-1:0] P_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, MEAS} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_sync1;
    logic               r_s;
    logic               r_s_prev;
    logic [CNT_W-1:0]   r_p_run;
    logic [CNT_W-1:0]   r_h_run;
    logic [CNT_W-1:0]   r_cap_p;
    logic [CNT_W-1:0]   r_cap_h;
    logic [REM_W-1:0]   r_rem;
    logic [3:0]         r_q;
    logic [2:0]         r_step;
    logic               r_busy;

    logic               w_rise;
    logic               w_timeout;
    logic               w_capture;
    logic               w_div_done;
    logic [1:0]         w_k;
    logic [REM_W-1:0]   w_sub;
    logic               w_ge;
    logic [REM_W-1:0]   w_rem_init;

    assign w_rise     = r_s & ~r_s_prev;
    // Rise has priority over timeout; no re-fire while already stuck.
    assign w_timeout  = ena & ~w_rise & ~stuck & (r_p_run == P_LAST);
    assign w_capture  = ena & w_rise & (r_state == MEAS);
    assign w_div_done = r_busy & (r_step == 3'd4);
    // Step index counts down 3..0 while r_step counts up 0..3.
    assign w_k        = 2'(2'd3 - r_step[1:0]);
    assign w_sub      = REM_W'(r_cap_p) << w_k;
    assign w_ge       = (r_rem >= w_sub);
    // 10*h as 8h + 2h, taken from the live counter at the capture edge.
    assign w_rem_init = (REM_W'(r_h_run) << 3) + (REM_W'(r_h_run) << 1);

    // Input synchronizer and edge-detect register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_s      <= 1'b0;
            r_s_prev <= 1'b0;
        end else begin
            r_sync1  <= pwm_in;
            r_s      <= r_sync1;
            r_s_prev <= r_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // FSM next state.
    always_comb begin
        w_state_next = r_state;
        if (!ena)           w_state_next = IDLE;
        else if (w_rise)    w_state_next = MEAS;
        else if (w_timeout) w_state_next = IDLE;
    end

    // Running period / high-time counters; the edge cycle counts as 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_run <= '0;
            r_h_run <= '0;
        end else if (!ena) begin
            r_p_run <= '0;
            r_h_run <= '0;
        end else if (w_rise) begin
            r_p_run <= CNT_W'(1);
            r_h_run <= CNT_W'(1);
        end else begin
            if (r_p_run != P_MAX)          r_p_run <= r_p_run + CNT_W'(1);
            if (r_s && (r_h_run != P_MAX)) r_h_run <= r_h_run + CNT_W'(1);
        end
    end

    // Capture, restoring divider and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_p    <= '0;
            r_cap_h    <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_step     <= '0;
            r_busy     <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
            duty       <= '0;
            valid      <= 1'b0;
            stuck      <= 1'b0;
        end else if (!ena) begin
            r_busy <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            // A completing result is published even if a new capture lands now.
            if (w_div_done) begin
                period_cnt <= r_cap_p;
                high_cnt   <= r_cap_h;
                duty       <= r_q;
                valid      <= 1'b1;
            end
            if (w_capture) begin
                r_cap_p <= r_p_run;
                r_cap_h <= r_h_run;
                r_rem   <= w_rem_init;
                r_q     <= '0;
                r_step  <= '0;
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                if (r_step == 3'd4) begin
                    r_busy <= 1'b0;
                end else begin
                    if (w_ge) begin
                        r_rem    <= r_rem - w_sub;
                        r_q[w_k] <= 1'b1;
                    end
                    r_step <= r_step + 3'd1;
                end
            end
            if (w_rise) stuck <= 1'b0;
            if (w_timeout) begin
                stuck      <= 1'b1;
                period_cnt <= '0;
                high_cnt   <= '0;
                duty       <= r_s ? 4'd10 : 4'd0;
                valid      <= 1'b1;
                r_busy     <= 1'b0;
            end
        end
    end

endmodule
